// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: two-master round-robin arbiter for one peripheral bus port.
// Ports: clk/rstn; m0_*/m1_* request side (req, addr, w_rb, acc, wdata in;
//   resp, fault out); m_rdata shared read data; s_* registered slave command,
//   s_req issue strobe, s_rdata/s_resp/s_fault slave return.
module gpio_bus_arbiter #(
   parameter int AW      = 3,
   parameter int DW      = 32,
   parameter int ACCW    = 2,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            m0_req,
   input  logic [AW-1:0]   m0_addr,
   input  logic            m0_w_rb,
   input  logic [ACCW-1:0] m0_acc,
   input  logic [DW-1:0]   m0_wdata,
   input  logic            m1_req,
   input  logic [AW-1:0]   m1_addr,
   input  logic            m1_w_rb,
   input  logic [ACCW-1:0] m1_acc,
   input  logic [DW-1:0]   m1_wdata,
   output logic            m0_resp,
   output logic            m0_fault,
   output logic            m1_resp,
   output logic            m1_fault,
   output logic [DW-1:0]   m_rdata,
   output logic [AW-1:0]   s_addr,
   output logic            s_w_rb,
   output logic [ACCW-1:0] s_acc,
   output logic [DW-1:0]   s_wdata,
   output logic            s_req,
   input  logic [DW-1:0]   s_rdata,
   input  logic            s_resp,
   input  logic            s_fault
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t          state_q;
   logic            last_q;
   logic            gnt_q;
   logic [7:0]      cnt_q;
   logic            s_req_q;
   logic            m0_resp_q, m0_fault_q;
   logic            m1_resp_q, m1_fault_q;
   logic [DW-1:0]   rdata_q;
   logic [AW-1:0]   s_addr_q;
   logic            s_w_rb_q;
   logic [ACCW-1:0] s_acc_q;
   logic [DW-1:0]   s_wdata_q;
   logic            win_d;

   // On a tie the master that did not win last time goes first.
   always_comb begin
      win_d = 1'b0;
      if (m0_req && m1_req) win_d = ~last_q;
      else                  win_d = m1_req;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         gnt_q      <= 1'b0;
         cnt_q      <= '0;
         s_req_q    <= 1'b0;
         m0_resp_q  <= 1'b0;
         m0_fault_q <= 1'b0;
         m1_resp_q  <= 1'b0;
         m1_fault_q <= 1'b0;
         rdata_q    <= '0;
         s_addr_q   <= '0;
         s_w_rb_q   <= 1'b0;
         s_acc_q    <= '0;
         s_wdata_q  <= '0;
      end else begin
         s_req_q    <= 1'b0;
         m0_resp_q  <= 1'b0;
         m0_fault_q <= 1'b0;
         m1_resp_q  <= 1'b0;
         m1_fault_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (m0_req || m1_req) begin
                  gnt_q     <= win_d;
                  last_q    <= win_d;
                  s_addr_q  <= win_d ? m1_addr  : m0_addr;
                  s_w_rb_q  <= win_d ? m1_w_rb  : m0_w_rb;
                  s_acc_q   <= win_d ? m1_acc   : m0_acc;
                  s_wdata_q <= win_d ? m1_wdata : m0_wdata;
                  s_req_q   <= 1'b1;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               // s_fault is combinational from the slave during s_req.
               if (s_fault) begin
                  m0_fault_q <= ~gnt_q;
                  m1_fault_q <= gnt_q;
                  state_q    <= DONE;
               end else begin
                  cnt_q   <= '0;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               // A response in the last allowed cycle beats the timeout.
               if (s_resp) begin
                  rdata_q   <= s_rdata;
                  m0_resp_q <= ~gnt_q;
                  m1_resp_q <= gnt_q;
                  state_q   <= DONE;
               end else if (cnt_q == TO_LAST) begin
                  m0_fault_q <= ~gnt_q;
                  m1_fault_q <= gnt_q;
                  state_q    <= DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_req    = s_req_q;
   assign m0_resp  = m0_resp_q;
   assign m0_fault = m0_fault_q;
   assign m1_resp  = m1_resp_q;
   assign m1_fault = m1_fault_q;
   assign m_rdata  = rdata_q;
   assign s_addr   = s_addr_q;
   assign s_w_rb   = s_w_rb_q;
   assign s_acc    = s_acc_q;
   assign s_wdata  = s_wdata_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter: directed bench with a completion scoreboard
// and a small behavioural slave.
module tb_gpio_bus_arbiter;

   localparam int AW = 3;
   localparam int DW = 32;
   localparam int ACCW = 2;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            m0_req = 1'b0, m1_req = 1'b0;
   logic [AW-1:0]   m0_addr = '0, m1_addr = '0;
   logic            m0_w_rb = 1'b0, m1_w_rb = 1'b0;
   logic [ACCW-1:0] m0_acc = '0, m1_acc = '0;
   logic [DW-1:0]   m0_wdata = '0, m1_wdata = '0;
   logic            m0_resp, m0_fault, m1_resp, m1_fault;
   logic [DW-1:0]   m_rdata;
   logic [AW-1:0]   s_addr;
   logic            s_w_rb;
   logic [ACCW-1:0] s_acc;
   logic [DW-1:0]   s_wdata;
   logic            s_req;
   logic [DW-1:0]   s_rdata = '0;
   logic            s_resp = 1'b0;
   logic            s_fault;

   gpio_bus_arbiter #(
      .AW(AW), .DW(DW), .ACCW(ACCW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rstn(rstn),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_w_rb(m0_w_rb),
      .m0_acc(m0_acc), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_w_rb(m1_w_rb),
      .m1_acc(m1_acc), .m1_wdata(m1_wdata),
      .m0_resp(m0_resp), .m0_fault(m0_fault),
      .m1_resp(m1_resp), .m1_fault(m1_fault),
      .m_rdata(m_rdata),
      .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc),
      .s_wdata(s_wdata), .s_req(s_req),
      .s_rdata(s_rdata), .s_resp(s_resp), .s_fault(s_fault)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave: answers resp_delay cycles after s_req (0 = never).
   int          resp_delay = 1;
   int          pend = 0;
   logic        fault_mode = 1'b0;
   logic [31:0] slv_data = '0;

   assign s_fault = fault_mode & s_req;

   always @(posedge clk) begin
      s_resp <= 1'b0;
      if (s_req && resp_delay > 0) begin
         if (resp_delay == 1) begin
            s_resp  <= 1'b1;
            s_rdata <= slv_data;
         end else begin
            pend <= resp_delay - 1;
         end
      end else if (pend > 0) begin
         pend <= pend - 1;
         if (pend == 1) begin
            s_resp  <= 1'b1;
            s_rdata <= slv_data;
         end
      end
   end

   logic [3:0] pulses;
   assign pulses = {m0_resp, m0_fault, m1_resp, m1_fault};

   typedef struct {
      logic [3:0]  p;
      logic [31:0] rd;
      bit          ckrd;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   base = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] p, input logic [31:0] rd,
                       input bit ckrd, input int lat);
      exp_t e;
      e.p = p;
      e.rd = rd;
      e.ckrd = ckrd;
      e.lat = lat;
      sb.push_back(e);
   endtask

   // Waits for the next completion pulse, pops and compares.
   task automatic wait_done(input string tag, input int budget);
      exp_t e;
      bit   got;
      int   sl;
      got = 1'b0;
      sl = -1;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (s_req && sl < 0) sl = cyc - base;
         if (pulses != 4'b0) got = 1'b1;
      end
      chk({tag, "_seen"}, 64'(got), 64'd1);
      if (!got) return;
      chk({tag, "_sbq"}, 64'(sb.size() > 0), 64'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk({tag, "_pulse"}, 64'(pulses), 64'(e.p));
      chk({tag, "_lat"}, 64'(cyc - base), 64'(e.lat));
      chk({tag, "_sreqlat"}, 64'(sl), 64'd1);
      if (e.ckrd) chk({tag, "_rdata"}, 64'(m_rdata), 64'(e.rd));
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out", 64'({s_req, pulses, s_addr, s_w_rb, s_acc}), 64'd0);
      chk("rst_data", {m_rdata, s_wdata}, 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      // Single read by m0
      slv_data = 32'h0000_00A5;
      resp_delay = 1;
      base = cyc;
      m0_addr = 3'd0; m0_w_rb = 1'b0; m0_acc = 2'd2;
      m0_req = 1'b1;
      push(4'b1000, 32'hA5, 1'b1, 3);
      wait_done("rd0", 10);
      m0_req = 1'b0;
      chk("rd0_cmd", 64'({s_addr, s_w_rb, s_acc}), 64'({3'd0, 1'b0, 2'd2}));
      @(negedge clk);
      chk("rd0_quiet", 64'(pulses), 64'd0);

      // Slave fault on an m1 write
      fault_mode = 1'b1;
      resp_delay = 0;
      base = cyc;
      m1_addr = 3'd2; m1_w_rb = 1'b1; m1_acc = 2'd1;
      m1_wdata = 32'hDEAD_BEEF;
      m1_req = 1'b1;
      push(4'b0001, 32'h0, 1'b0, 2);
      wait_done("flt1", 10);
      m1_req = 1'b0;
      chk("flt1_cmd", 64'({s_addr, s_w_rb, s_acc}), 64'({3'd2, 1'b1, 2'd1}));
      chk("flt1_wdata", 64'(s_wdata), 64'h0000_0000_DEAD_BEEF);
      fault_mode = 1'b0;
      @(negedge clk);

      // Round robin after a fresh reset
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      resp_delay = 1;
      slv_data = 32'h11;
      m0_addr = 3'd1; m0_w_rb = 1'b0;
      m1_addr = 3'd6; m1_w_rb = 1'b0;
      base = cyc;
      m0_req = 1'b1;
      m1_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push((k % 2 == 0) ? 4'b1000 : 4'b0010, 32'h11, 1'b1, 3);
         wait_done($sformatf("rr%0d", k), 10);
         if (k % 2 == 0) m0_req = 1'b0;
         else            m1_req = 1'b0;
         base = cyc + 1;
         @(negedge clk);
         if (k < 3) begin
            if (k % 2 == 0) m0_req = 1'b1;
            else            m1_req = 1'b1;
         end
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      @(negedge clk);

      // Timeout on m0 with m1 pending
      resp_delay = 0;
      base = cyc;
      m0_addr = 3'd3;
      m0_req = 1'b1;
      m1_req = 1'b1;
      push(4'b0100, 32'h0, 1'b0, 2 + TO);
      wait_done("to0", 20);
      m0_req = 1'b0;
      resp_delay = 1;
      slv_data = 32'h33;
      base = cyc + 1;
      push(4'b0010, 32'h33, 1'b1, 3);
      wait_done("to_m1", 10);
      m1_req = 1'b0;
      @(negedge clk);

      // Response in the last allowed WAIT cycle
      resp_delay = TO;
      slv_data = 32'h5A;
      base = cyc;
      m0_addr = 3'd4;
      m0_req = 1'b1;
      push(4'b1000, 32'h5A, 1'b1, 2 + TO);
      wait_done("edge", 20);
      m0_req = 1'b0;
      @(negedge clk);

      // Reset in the middle of WAIT; late response is dropped
      resp_delay = 3;
      slv_data = 32'h77;
      base = cyc;
      m0_addr = 3'd5;
      m0_wdata = 32'h1234;
      m0_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      m0_req = 1'b0;
      #1;
      chk("rstw_out", 64'({s_req, pulses, s_addr, s_w_rb, s_acc}), 64'd0);
      chk("rstw_data", {m_rdata, s_wdata}, 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("rstw_quiet%0d", k), 64'({s_req, pulses}), 64'd0);
      end
      resp_delay = 1;
      slv_data = 32'h99;
      base = cyc;
      m0_req = 1'b1;
      m1_req = 1'b1;
      push(4'b1000, 32'h99, 1'b1, 3);
      wait_done("rstw_tie", 10);
      m0_req = 1'b0;
      m1_req = 1'b0;
      chk("rstw_addr", 64'(s_addr), 64'd5);
      repeat (6) @(negedge clk);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
